// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared types and widths for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int unsigned c_WORD_W = 32;  // data word width
  localparam int unsigned c_BE_W   = 4;   // one enable per byte lane
  localparam int unsigned c_CNT_W  = 4;   // wait-state counter, LATENCY 0..15

  // Responder transaction phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/dm_array.sv
`default_nettype none
// ============================================================================
// Module      : dm_array
// Description : NWORDS x 32 storage, byte-enabled synchronous write,
//               combinational read at the same index.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_array
  import mips_mem_pkg::*;
#(
  parameter int NWORDS = 128,
  parameter int IDX_W  = $clog2(NWORDS)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [c_BE_W-1:0]   i_be,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [c_WORD_W-1:0] i_wdata,
  output logic [c_WORD_W-1:0] o_rdata
);

  // Contents are deliberately not reset
  logic [c_WORD_W-1:0] r_mem [NWORDS];

  // Update only the byte lanes whose enable is set
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(c_BE_W); b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule : dm_array
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Memory-side end of the load/store interface. Accepts one
//               request, waits LATENCY cycles, performs a byte-enabled write
//               or a word read, and returns a held response.
//               Optional macro DM_RESPONDER_ERR_EN enables misaligned /
//               out-of-range address faulting (rsp_err).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder
  import mips_mem_pkg::*;
#(
  parameter int NWORDS  = 128,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [c_BE_W-1:0]   req_be,
  input  logic [31:0]         req_addr,
  input  logic [c_WORD_W-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [c_WORD_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int                 c_IDX_W = $clog2(NWORDS);
  localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(LATENCY);

  state_t                r_state, w_next;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_we;
  logic [c_BE_W-1:0]     r_be;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_WORD_W-1:0]   r_wdata;
  logic                  r_bad;
  logic                  r_rsp_valid;
  logic [c_WORD_W-1:0]   r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  w_req_bad;
  logic                  w_mem_we;
  logic [c_WORD_W-1:0]   w_mem_rdata;

`ifdef DM_RESPONDER_ERR_EN
  localparam logic [31:0] c_LIMIT = 32'(4 * NWORDS);
  // Fault misaligned addresses and anything beyond the array
  assign w_req_bad = (req_addr[1:0] != 2'b00) || (req_addr >= c_LIMIT);
  assign rsp_err   = r_rsp_err;
`else
  // Low bits and bits above the index are ignored, so addresses wrap
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, req_addr[1:0], req_addr[31:c_IDX_W+2], r_rsp_err};
  assign w_req_bad     = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  // A reset on the access edge must suppress the write
  assign w_mem_we = (r_state == ACCESS) && r_we && !r_bad && !reset;

  dm_array #(
    .NWORDS (NWORDS),
    .IDX_W  (c_IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; WAIT is skipped entirely when LATENCY is zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = (LATENCY > 0) ? WAIT : ACCESS;
      WAIT:    if (r_cnt == c_CNT_W'(1)) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_be    <= req_be;
            r_idx   <= req_addr[c_IDX_W+1:2];
            r_wdata <= req_wdata;
            r_bad   <= w_req_bad;
            r_cnt   <= c_LAT;
          end
        end
        WAIT: r_cnt <= r_cnt - c_CNT_W'(1);
        ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= (r_we || r_bad) ? '0 : w_mem_rdata;
          r_rsp_err   <= r_bad;
        end
        RESP: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder. Instance 0 uses
//               LATENCY=2 with bench-driven rsp_ready; instance 1 uses
//               LATENCY=0 with rsp_ready tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  localparam int NW = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready0;
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  dm_responder #(.NWORDS(NW), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  dm_responder #(.NWORDS(NW), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          cyc = 0;
  logic [31:0] mmem      [2][NW];
  bit          m_known   [2];
  bit          m_out     [2];
  bit          m_resp    [2];
  bit          m_valid   [2];
  bit          m_err     [2];
  bit          m_acc     [2];
  logic [31:0] m_rdata   [2];
  int          m_acc_edge[2];
  bit          t_we      [2];
  logic [3:0]  t_be      [2];
  logic [31:0] t_addr    [2];
  logic [31:0] t_wdata   [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DM_RESPONDER_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * NW));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin : model
    int  idx;
    bit  bad;
    bit  rdy;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 1'b0;
      rdy = (k == 0) ? rsp_ready0 : 1'b1;
      if (rst[k]) begin
        m_known[k] = 1'b1; m_out[k] = 1'b0; m_resp[k] = 1'b0;
        m_valid[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = 32'h0;
      end else if (!m_known[k]) begin
        // nothing defined before the first reset
      end else if (!m_out[k]) begin
        if (req_valid[k]) begin
          m_out[k] = 1'b1; m_acc[k] = 1'b1; m_acc_edge[k] = cyc;
          t_we[k] = req_we[k]; t_be[k] = req_be[k];
          t_addr[k] = req_addr[k]; t_wdata[k] = req_wdata[k];
        end
      end else if (!m_resp[k]) begin
        if (cyc == m_acc_edge[k] + lat_of(k) + 1) begin
          idx = int'((t_addr[k] >> 2) % NW);
          bad = addr_bad(t_addr[k]);
          if (t_we[k] && !bad)
            for (int b = 0; b < 4; b++)
              if (t_be[k][b]) mmem[k][idx][8*b +: 8] = t_wdata[k][8*b +: 8];
          m_rdata[k] = (t_we[k] || bad) ? 32'h0 : mmem[k][idx];
          m_err[k]   = bad;
          m_valid[k] = 1'b1;
          m_resp[k]  = 1'b1;
        end
      end else if (rdy) begin
        m_valid[k] = 1'b0; m_out[k] = 1'b0; m_resp[k] = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_known[k]) begin
        chk($sformatf("u%0d.req_ready", k), 32'(req_ready[k]), 32'(!m_out[k] && !rst[k]));
        chk($sformatf("u%0d.rsp_valid", k), 32'(rsp_valid[k]), 32'(m_valid[k]));
        chk($sformatf("u%0d.rsp_rdata", k), rsp_rdata[k], m_rdata[k]);
        chk($sformatf("u%0d.rsp_err", k),   32'(rsp_err[k]),   32'(m_err[k]));
        chk($sformatf("u%0d.busy", k),      32'(busy[k]),      32'(m_out[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int k, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    req_we[k] = we; req_be[k] = be; req_addr[k] = addr; req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    acc = -1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (m_acc[k]) begin acc = m_acc_edge[k]; break; end
    end
    req_valid[k] = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL accept_timeout u%0d actual=none required=accept", k);
    end
  endtask

  task automatic get_rsp(input int k, input int acc, output logic [31:0] rd,
                         output logic er, output int lat);
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) begin
        rd = rsp_rdata[k]; er = rsp_err[k]; lat = cyc - acc; break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL rsp_timeout u%0d actual=none required=rsp_valid", k);
    end
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 60; n++) begin
      if (!m_out[k]) return;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL idle_timeout u%0d actual=busy required=idle", k);
  endtask

  task automatic xact(input int k, input bit we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er, output int acc);
    int lat;
    issue(k, we, be, addr, wdata, acc);
    get_rsp(k, acc, rd, er, lat);
    chk($sformatf("u%0d.latency", k), 32'(lat), (k == 0) ? 32'd3 : 32'd1);
    wait_idle(k);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          a0, a1, a2, lat;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_be[k] = 4'h0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
    end
    rsp_ready0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // Write then read back at 0x10
    xact(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, a0);
    chk("t1_wr_rdata", rd, 32'h0);
    chk("t1_wr_err", 32'(er), 32'h0);
    xact(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, er, a0);
    chk("t1_rd_rdata", rd, 32'hDEADBEEF);
    // Seed words 0 and 8 for later tests
    xact(0, 1'b1, 4'hF, 32'h0,  32'h01020304, rd, er, a0);
    xact(0, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, rd, er, a0);

    // Partial byte write
    xact(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, rd, er, a0);
    xact(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, a0);
    chk("t2_be_rdata", rd, 32'hDE22BE44);
    chk("model_word4", mmem[0][4], 32'hDE22BE44);

    // Backpressure with a competing request held on the input
    rsp_ready0 = 1'b0;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, a0);
    req_we[0] = 1'b0; req_be[0] = 4'hF; req_addr[0] = 32'h0; req_valid[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", 32'(rsp_valid[0]), 32'h1);
      chk("t3_hold_rdata", rsp_rdata[0], 32'hDE22BE44);
      chk("t3_hold_ready", 32'(req_ready[0]), 32'h0);
    end
    rsp_ready0 = 1'b1;
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0, a1);
    chk("t3_accept_gap", 32'(a1 - a0), 32'd10);
    get_rsp(0, a1, rd, er, lat);
    chk("t3_second_rdata", rd, 32'h01020304);
    wait_idle(0);

    // Address faults (or wrap when faulting is compiled out)
    xact(0, 1'b0, 4'hF, 32'h202, 32'h0, rd, er, a0);
`ifdef DM_RESPONDER_ERR_EN
    chk("t4_misalign_err", 32'(er), 32'h1);
    chk("t4_misalign_rdata", rd, 32'h0);
`else
    chk("t4_wrap_err", 32'(er), 32'h0);
    chk("t4_wrap_rdata", rd, 32'h01020304);
`endif
    xact(0, 1'b1, 4'hF, 32'h200, 32'hCAFEF00D, rd, er, a0);
    xact(0, 1'b0, 4'hF, 32'h0, 32'h0, rd, er, a0);
`ifdef DM_RESPONDER_ERR_EN
    chk("t4_word0_kept", rd, 32'h01020304);
`else
    chk("t4_word0_wrapped", rd, 32'hCAFEF00D);
`endif

    // Reset while waiting abandons the write
    issue(0, 1'b1, 4'hF, 32'h20, 32'h12345678, a0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t5_ready_after_rst", 32'(req_ready[0]), 32'h1);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid[0]), 32'h0);
    end
    @(posedge clk); #1;
    xact(0, 1'b0, 4'hF, 32'h20, 32'h0, rd, er, a0);
    chk("t5_word8_kept", rd, 32'hA5A5A5A5);

    // Zero latency, back-to-back reads
    xact(1, 1'b1, 4'hF, 32'h0, 32'h0000AAAA, rd, er, a0);
    xact(1, 1'b1, 4'hF, 32'h4, 32'h0000BBBB, rd, er, a0);
    xact(1, 1'b1, 4'hF, 32'h8, 32'h0000CCCC, rd, er, a0);
    xact(1, 1'b0, 4'hF, 32'h0, 32'h0, rd, er, a0);
    chk("t6_rd0", rd, 32'h0000AAAA);
    xact(1, 1'b0, 4'hF, 32'h4, 32'h0, rd, er, a1);
    chk("t6_rd1", rd, 32'h0000BBBB);
    xact(1, 1'b0, 4'hF, 32'h8, 32'h0, rd, er, a2);
    chk("t6_rd2", rd, 32'h0000CCCC);
    chk("t6_gap01", 32'(a1 - a0), 32'd3);
    chk("t6_gap12", 32'(a2 - a1), 32'd3);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule : tb_dm_responder
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder: the memory-side end of the CPU load/store interface. It accepts one request at a time from the MEM stage, or from a future stalling memory stage, over a valid/ready handshake. It inserts a programmable number of wait states, performs a byte-enabled word write or a word read, and returns a response over a second valid/ready handshake. It replaces the single-cycle data memory when multi-cycle memory timing must be modelled.

Parameters:
NWORDS, 128, number of 32-bit words in the array; power of two, minimum 2.
LATENCY, 2, wait-state cycles between accept and access; range 0..15.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = write, 0 = read.
req_be  in  4  byte enables; bit i covers data[8i+7:8i].
req_addr  in  32  byte address.
req_wdata  in  32  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  requester accepts the response.
rsp_rdata  out  32  read data; 0 for writes and for errors.
rsp_err  out  1  request faulted.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP. Reset has priority over every transition.
- Reset:
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; busy = 0.
  - req_ready = 0 while reset is high.
  - Array contents are not reset.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch we, be, addr and wdata; load the wait counter with LATENCY.
  - Go to WAIT if LATENCY > 0, else go to ACCESS.
- WAIT:
  - Counter decrements each cycle.
  - Leave for ACCESS on the edge where the counter is 1, so WAIT lasts exactly LATENCY cycles.
- ACCESS, one cycle. At its closing edge:
  - Write: bytes with be[i] = 1 are updated; the others are unchanged. be = 0 is a legal no-op, not an error.
  - Read: the full word is registered into rsp_rdata regardless of be.
  - rsp_valid is set and the FSM goes to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is sampled high.
  - On handshake: rsp_valid = 0, then IDLE. rsp_rdata and rsp_err hold their last values.
- Latency: for a request accepted at edge T, rsp_valid is high after edge T+LATENCY+1.
  - Throughput with rsp_ready = 1 is one transaction per LATENCY+3 cycles.
- Outstanding requests: at most one.
  - req_ready = 0 in WAIT, ACCESS and RESP.
  - Request inputs are ignored outside IDLE.
  - IDLE does not accept on the same edge as the RESP handshake.
- Indexing: word index = req_addr[2+log2(NWORDS)-1 : 2].
- Reset mid-operation:
  - A transaction not yet past its ACCESS edge is abandoned; no write occurs.
  - A reset coinciding with the ACCESS edge suppresses the write.
  - No response is ever issued for an abandoned transaction.

Optional Feature:
Macro: DM_RESPONDER_ERR_EN
- Defined:
  - Error condition: req_addr[1:0] != 0, or req_addr >= 4*NWORDS.
  - On error, ACCESS performs no write, rsp_rdata = 0 and rsp_err = 1.
  - Latency is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - req_addr[1:0] and all address bits above the index are ignored, so addresses wrap modulo 4*NWORDS.

Decomposition:
- Package mips_mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, ACCESS, RESP);
  - word width 32 and byte-enable width 4;
  - latency counter width 4.
- Sub-module dm_array:
  - NWORDS x 32 synchronous-write array, with byte enables, a combinational read, and index input.
  - Instantiated once.
- The FSM, counter and error check live in dm_responder.

Test Plan:
1. Write and read back (LATENCY=2): write 0xDEADBEEF to 0x10 with be=4'b1111 → rsp_valid after 3 edges, rsp_err=0, rsp_rdata=0. Then read 0x10 → rsp_rdata=0xDEADBEEF.
2. Byte enables: write 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x10 → read of 0x10 returns 0xDE22BE44.
3. Backpressure: hold rsp_ready=0 for 5 cycles during RESP while driving a new req_valid → rsp_valid, rsp_rdata and rsp_err are stable; req_ready=0; the new request is not accepted until after the handshake and a return to IDLE.
4. Errors (ERR_EN defined, NWORDS=128):
   - Read 0x202 → rsp_err=1, rsp_rdata=0.
   - Write 0xCAFEF00D to 0x200 → rsp_err=1; word 0 unchanged.
   - With ERR_EN undefined, the same write lands in word 0 and rsp_err=0.
5. Reset in WAIT: accept a write of 0x12345678 to 0x20, assert reset one cycle later → no response issued; word 8 unchanged; req_ready=1 on the first cycle after reset drops.
6. LATENCY=0, rsp_ready tied 1, back-to-back reads of 0x0, 0x4, 0x8 → each rsp_valid follows its accept by 1 edge; accepts are spaced exactly 3 cycles apart.
